// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM state encoding.
// Imported by the exec unit and the ALU control decoder.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_unit_seq_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Ports: start_i/flush_i control, a_i/b_i operands, done_o/product_o result.
module seq_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  assign acc_nxt = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  // product is the accumulator after the final iteration
  assign product_o = acc_nxt;
  assign done_o    = busy_q & last & ~flush_i;

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      mcand_d = a_i;
      mplr_d  = b_i;
      acc_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d   = acc_nxt;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: 1-cycle logic/add/sub, WIDTH-cycle multiply.
// Ports: valid_i/ready_o in, valid_o/data_o/zero_o registered out, flush_i.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] comb_res;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;
  assign mul_start = accept & (ALUCtrl_i == ALU_MUL);

  always_comb begin
    case (ALUCtrl_i)
      ALU_AND: comb_res = data1_i & data2_i;
      ALU_OR:  comb_res = data1_i | data2_i;
      ALU_ADD: comb_res = data1_i + data2_i;
      ALU_SUB: comb_res = data1_i - data2_i;
      default: comb_res = '0;
    endcase
  end

  seq_mul #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mul_start),
    .flush_i  (flush_i),
    .a_i      (data1_i),
    .b_i      (data2_i),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mul_start) begin
          state_d = MUL;
        end else if (accept) begin
          data_d  = comb_res;
          zero_d  = (comb_res == '0);
          valid_d = 1'b1;
        end
      end
      MUL: begin
        // flush beats completion on the same edge
        if (flush_i) begin
          state_d = IDLE;
        end else if (mul_done) begin
          data_d  = mul_prod;
          zero_d  = (mul_prod == '0);
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU; sits directly downstream of the ALU control decoder.
- Consumes the 3-bit ALU control code and two 32-bit operands.
- Issues a registered result with valid/ready handshake.
- and/or/add/sub complete in 1 cycle; mul runs as an iterative shift-add over WIDTH cycles and back-pressures the pipeline through ready_o.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration counter width; must be at least clog2(WIDTH)+1

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
flush_i  input  1  pipeline flush; kills any accepted or in-flight op
valid_i  input  1  operands/control valid this cycle
ALUCtrl_i  input  3  operation code from ALU control
data1_i  input  WIDTH  operand A
data2_i  input  WIDTH  operand B
ready_o  output  1  unit can accept an op this cycle
valid_o  output  1  data_o/zero_o hold a new result; one-cycle pulse
data_o  output  WIDTH  registered result
zero_o  output  1  registered (result == 0)

Behaviour:
- Reset (async, rst_i=1): state=IDLE, ready_o=1, valid_o=0, data_o=0, zero_o=0, counter/operand regs=0. Takes effect immediately, including mid-multiply; the partial product is discarded.
- Op codes: 000 and, 001 or, 010 add, 011 mul, 110 sub. Any other code produces result 0, zero_o=1, and a normal valid_o pulse.
- Accept: a rising edge where valid_i=1, ready_o=1 and flush_i=0. valid_i while ready_o=0 is ignored and not queued; upstream holds its op.
- States:
  - IDLE: ready_o=1.
    - Accept non-mul: data_o/zero_o load the result; valid_o=1 next cycle; stay IDLE. Throughput is 1 op/cycle, latency 1.
    - Accept mul: load mcand=data1_i, mplr=data2_i, acc=0, cnt=0; go to MUL.
  - MUL: ready_o=0. Each edge: if mplr[0] then acc += mcand; mcand <<= 1; mplr >>= 1; cnt++.
    - On the edge performing iteration WIDTH (cnt==WIDTH-1): data_o = final acc, zero_o updated, valid_o=1 next cycle, go to IDLE.
    - Mul accepted at edge T0 gives valid_o high in the cycle after edge T0+WIDTH. ready_o is low in the cycles after edges T0 … T0+WIDTH-1.
- Arithmetic:
  - add/sub modulo 2^WIDTH; no overflow flag.
  - mul returns the low WIDTH bits of the product, identical for signed and unsigned operands.
- valid_o is low in every cycle not following a completion.
- data_o/zero_o hold their last value until the next completion.
- flush_i:
  - In IDLE: blocks acceptance that edge.
  - In MUL: abort, go to IDLE, no valid_o, data_o unchanged; ready_o=1 next cycle.
  - On the completion edge: flush wins; no valid_o and data_o unchanged.
- No early termination on mplr==0; mul latency is fixed.

Decomposition:
- Shared package alu_pkg:
  - op-code constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_MUL=3'b011, ALU_SUB=3'b110. The ALU control decoder uses the same constants.
  - State encoding IDLE/MUL.
- One sub-module, seq_mul: holds the shift-add datapath and counter, with interface start/flush/done/product.
- alu_exec_unit keeps the FSM, the combinational logic ops, and the output registers.

Test Plan:
- add 5+7, then and 0xF0F0&0x0FF0 on back-to-back cycles -> valid_o high two consecutive cycles, data_o=12 then 0x00F0, ready_o stays 1.
- sub 9-9 -> data_o=0, zero_o=1; sub 0-1 -> data_o=0xFFFFFFFF, zero_o=0; or code 3'b100 -> data_o=0, zero_o=1, valid_o pulses.
- mul 3*4 at edge T0 -> ready_o=0 for 32 cycles; valid_o only in the cycle after T0+32 with data_o=12. An add presented with valid_i during busy is ignored and produces no extra valid_o.
- mul 0xFFFFFFFF*0xFFFFFFFF -> data_o=0x00000001; mul 0x00010000*0x00010000 -> data_o=0, zero_o=1.
- mul 6*7 with flush_i on the 10th busy cycle -> no valid_o, ready_o=1 next cycle, data_o keeps its prior value; a following mul 6*7 then gives 42.
- rst_i asserted asynchronously (between edges) mid-mul -> all outputs 0 and ready_o=1 immediately. After release, add 1+1 -> data_o=2, latency 1.
